// File: rtl/c_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : c_sel_pkg
//  Brief    : Shared constants, FSM state encoding and helper functions for
//             the multi-word carry-select add sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package c_sel_pkg;

    // Width of one adder slice; every operand is processed in chunks of this size.
    localparam int CHUNK_W = 21;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to index WORDS chunks; never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage : c_sel_pkg
`default_nettype wire

// File: rtl/c_sel_multiword_add_ctrl_csa.sv
`default_nettype none
// ============================================================================
//  Module   : C_Sel_A_21bit
//  Brief    : 21-bit carry-select adder built from three 7-bit blocks. Each
//             block precomputes its sum for carry-in 0 and 1; the incoming
//             block carry only drives the final select.
//  Revision : 1.0 - initial release
// ============================================================================
module C_Sel_A_21bit (
    input  logic [20:0] a,
    input  logic [20:0] b,
    input  logic        cin,
    output logic [20:0] s,
    output logic        cout
);

    localparam int BLK_W = 7;
    localparam int NBLK  = 3;

    // Carry entering each block; w_carry[NBLK] is the adder carry-out.
    logic [NBLK:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar g = 0; g < NBLK; g++) begin : g_blk
            logic [BLK_W:0] w_res0;
            logic [BLK_W:0] w_res1;

            // Both speculative results are ready before the block carry arrives.
            assign w_res0 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
            assign w_res1 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]}
                          + {{BLK_W{1'b0}}, 1'b1};

            assign s[g*BLK_W +: BLK_W] = w_carry[g] ? w_res1[BLK_W-1:0] : w_res0[BLK_W-1:0];
            assign w_carry[g+1]        = w_carry[g] ? w_res1[BLK_W]     : w_res0[BLK_W];
        end
    endgenerate

    assign cout = w_carry[NBLK];

endmodule : C_Sel_A_21bit
`default_nettype wire

// File: rtl/c_sel_multiword_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : c_sel_multiword_add_ctrl
//  Brief    : Sequences a WORDS x 21-bit addition through a single shared
//             21-bit carry-select adder, one chunk per cycle, LSB chunk first,
//             with the carry chained through a register. Operands arrive and
//             results leave over valid/ready handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module c_sel_multiword_add_ctrl
    import c_sel_pkg::*;
#(
    parameter int WORDS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*CHUNK_W:1]   in_a,
    input  logic [WORDS*CHUNK_W:1]   in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*CHUNK_W:1]   out_sum,
    output logic                     out_cout
);

    localparam int             IW       = idx_width(WORDS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(WORDS - 1);

    state_t                    r_state;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_out_cout;
    logic [WORDS*CHUNK_W:1]    r_sum;
    logic [WORDS*CHUNK_W:1]    r_op_a;
    logic [WORDS*CHUNK_W:1]    r_op_b;
    logic                      r_carry;
    logic [IW-1:0]             r_idx;

    logic [CHUNK_W-1:0]        w_chunk_a;
    logic [CHUNK_W-1:0]        w_chunk_b;
    logic [CHUNK_W-1:0]        w_add_s;
    logic                      w_add_cout;

    // Operand chunk mux: the only logic between the operand registers and the adder.
    always_comb begin
        w_chunk_a = '0;
        w_chunk_b = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IW'(k)) begin
                w_chunk_a = r_op_a[CHUNK_W*k+1 +: CHUNK_W];
                w_chunk_b = r_op_b[CHUNK_W*k+1 +: CHUNK_W];
            end
        end
    end

    C_Sel_A_21bit u_adder (
        .a    (w_chunk_a),
        .b    (w_chunk_b),
        .cin  (r_carry),
        .s    (w_add_s),
        .cout (w_add_cout)
    );

    // Sequencer FSM with registered handshake outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_cout  <= 1'b0;
            r_sum       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // in_ready is held low for the first cycle after reset release.
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_op_a     <= in_a;
                        r_op_b     <= in_b;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_sum[CHUNK_W*k+1 +: CHUNK_W] <= w_add_s;
                        end
                    end
                    r_carry <= w_add_cout;
                    if (r_idx == LAST_IDX) begin
                        r_out_cout  <= w_add_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_out_cout;

endmodule : c_sel_multiword_add_ctrl
`default_nettype wire

// File: tb/tb_c_sel_multiword_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c_sel_multiword_add_ctrl
//  Brief    : Self-checking bench for the multi-word add sequencer. Two
//             instances (WORDS=3 and WORDS=1) share one set of stimulus
//             variables; sel1 routes in_valid and selects observed outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_c_sel_multiword_add_ctrl;

    logic        clk;
    logic        rst;
    logic        sel1;
    logic        in_valid;
    logic        out_ready;
    logic        in_cin;
    logic [63:1] in_a;
    logic [63:1] in_b;

    logic        r3_in_ready, r3_out_valid, r3_out_cout;
    logic [63:1] r3_out_sum;
    logic        r1_in_ready, r1_out_valid, r1_out_cout;
    logic [21:1] r1_out_sum;

    logic        ob_in_ready, ob_out_valid, ob_out_cout;
    logic [62:0] ob_sum;

    int tests_run    = 0;
    int tests_failed = 0;
    int accepted     = 0;
    int delivered    = 0;
    int words_cur    = 3;

    c_sel_multiword_add_ctrl #(.WORDS(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel1),
        .in_ready  (r3_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (r3_out_valid),
        .out_ready (out_ready & ~sel1),
        .out_sum   (r3_out_sum),
        .out_cout  (r3_out_cout)
    );

    c_sel_multiword_add_ctrl #(.WORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel1),
        .in_ready  (r1_in_ready),
        .in_a      (in_a[21:1]),
        .in_b      (in_b[21:1]),
        .in_cin    (in_cin),
        .out_valid (r1_out_valid),
        .out_ready (out_ready & sel1),
        .out_sum   (r1_out_sum),
        .out_cout  (r1_out_cout)
    );

    assign ob_in_ready  = sel1 ? r1_in_ready  : r3_in_ready;
    assign ob_out_valid = sel1 ? r1_out_valid : r3_out_valid;
    assign ob_out_cout  = sel1 ? r1_out_cout  : r3_out_cout;
    assign ob_sum       = sel1 ? {42'b0, r1_out_sum} : r3_out_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: offer operands, verify latency, hold result, then consume it.
    task automatic do_op(input string tag, input logic [62:0] a, input logic [62:0] b,
                         input logic cin, input logic [62:0] exp_sum, input logic exp_cout,
                         input int idle_gap, input int rdy_gap);
        int n;
        repeat (idle_gap) tick();
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        n = 0;
        while (!ob_in_ready && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            check({tag, "_accept_timeout"}, 64'(ob_in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        tick();                                   // acceptance edge E0
        accepted++;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_cin = ~cin;      // must not affect the captured operation
        n = 0;
        while (!ob_out_valid && n < 100) begin tick(); n++; end
        check({tag, "_latency"}, 64'(n), 64'(words_cur));
        repeat (rdy_gap) tick();
        check({tag, "_in_ready_done"}, 64'(ob_in_ready), 64'd0);
        check({tag, "_sum"}, 64'(ob_sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(ob_out_cout), 64'(exp_cout));
        if (ob_out_valid) delivered++;
        out_ready = 1'b1;
        tick();                                   // Ed
        out_ready = 1'b0;
        check({tag, "_valid_fall"}, 64'(ob_out_valid), 64'd0);
        check({tag, "_in_ready_after"}, 64'(ob_in_ready), 64'd1);
    endtask

    task automatic run_random(input string tag, input int nops);
        logic [62:0] a, b, mask;
        logic        cin;
        logic [63:0] gold;
        int          w;
        w    = words_cur * 21;
        mask = (w >= 63) ? {63{1'b1}} : ((63'd1 << w) - 63'd1);
        for (int i = 0; i < nops; i++) begin
            a    = {$urandom, $urandom} & {1'b0, mask};
            b    = {$urandom, $urandom} & {1'b0, mask};
            cin  = 1'($urandom_range(0, 1));
            gold = {1'b0, a} + {1'b0, b} + {63'd0, cin};
            do_op(tag, a, b, cin, gold[62:0] & mask, gold[w],
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; sel1 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_cin = 1'b0; in_a = '0; in_b = '0;
        tick(); tick();

        // Reset state of both instances.
        check("rst3_in_ready",  64'(ob_in_ready),  64'd0);
        check("rst3_out_valid", 64'(ob_out_valid), 64'd0);
        check("rst3_sum",       64'(ob_sum),       64'd0);
        check("rst3_cout",      64'(ob_out_cout),  64'd0);
        sel1 = 1'b1; #1;
        check("rst1_in_ready",  64'(ob_in_ready),  64'd0);
        check("rst1_out_valid", 64'(ob_out_valid), 64'd0);
        sel1 = 1'b0; #1;
        rst = 1'b0; #1;
        check("post_rst_in_ready_low", 64'(ob_in_ready), 64'd0);
        tick();
        check("post_rst_in_ready_high", 64'(ob_in_ready), 64'd1);

        // Directed WORDS=3 vectors.
        words_cur = 3;
        do_op("all_ones_plus1", 63'h7FFF_FFFF_FFFF_FFFF, 63'd1, 1'b0, 63'd0, 1'b1, 0, 0);
        do_op("carry_c0_c1", 63'h1F_FFFF, 63'd1, 1'b0, 63'h20_0000, 1'b0, 1, 0);
        do_op("carry_c1_c2", 63'h3FF_FFFF_FFFF, 63'd1, 1'b0, 63'h400_0000_0000, 1'b0, 0, 1);
        do_op("cin_only", 63'd0, 63'd0, 1'b1, 63'd1, 1'b0, 2, 0);
        do_op("alt_bits_cin", 63'h2AAA_AAAA_AAAA_AAAA, 63'h5555_5555_5555_5555, 1'b1,
              63'd0, 1'b1, 0, 0);

        // Back-pressure: result held, new request refused until consumed.
        in_a = 63'd100; in_b = 63'd200; in_cin = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!ob_in_ready && n < 100) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!ob_out_valid && n < 100) begin tick(); n++; end
        check("bp_first_sum", 64'(ob_sum), 64'd300);
        in_a = 63'd5; in_b = 63'd7; in_cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held",  64'(ob_out_valid), 64'd1);
            check("bp_sum_held",    64'(ob_sum),       64'd300);
            check("bp_cout_held",   64'(ob_out_cout),  64'd0);
            check("bp_in_ready_lo", 64'(ob_in_ready),  64'd0);
        end
        out_ready = 1'b1;
        tick();                                   // Ed
        out_ready = 1'b0;
        check("bp_valid_fall", 64'(ob_out_valid), 64'd0);
        check("bp_in_ready_hi", 64'(ob_in_ready), 64'd1);
        tick();                                   // Ed+1: pending request accepted
        in_valid = 1'b0;
        check("bp_accepted", 64'(ob_in_ready), 64'd0);
        n = 0;
        while (!ob_out_valid && n < 100) begin tick(); n++; end
        check("bp_second_latency", 64'(n), 64'd3);
        check("bp_second_sum", 64'(ob_sum), 64'd12);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset one cycle into ADD abandons the operation immediately.
        in_a = 63'd3; in_b = 63'd4; in_cin = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!ob_in_ready && n < 100) begin tick(); n++; end
        tick();                                   // E0
        in_valid = 1'b0;
        tick();                                   // one cycle into ADD
        rst = 1'b1; #1;
        check("mid_rst_valid", 64'(ob_out_valid), 64'd0);
        check("mid_rst_sum",   64'(ob_sum),       64'd0);
        check("mid_rst_cout",  64'(ob_out_cout),  64'd0);
        tick(); tick();
        check("mid_rst_no_result", 64'(ob_out_valid), 64'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_in_ready", 64'(ob_in_ready), 64'd1);
        do_op("after_rst_5p7", 63'd5, 63'd7, 1'b0, 63'd12, 1'b0, 0, 0);

        // Random traffic on the WORDS=3 instance.
        run_random("rnd3", 1000);

        // WORDS=1 instance: directed then random.
        sel1 = 1'b1; words_cur = 1; #1;
        do_op("w1_wrap", 63'h1F_FFFF, 63'd1, 1'b0, 63'd0, 1'b1, 0, 0);
        do_op("w1_simple", 63'd5, 63'd7, 1'b1, 63'd13, 1'b0, 0, 2);
        run_random("rnd1", 1000);

        check("accepted_vs_delivered", 64'(delivered), 64'(accepted));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_c_sel_multiword_add_ctrl
`default_nettype wire
